// File: rtl/trap_ctrl_mc_pkg.sv
// Shared definitions for the machine-mode trap controller: cause codes,
// CSR operation encodings, CSR select bit positions and FSM states.
package trap_ctrl_mc_pkg;

    localparam logic [4:0] M_SW_INT     = 5'd3;
    localparam logic [4:0] M_TIMER_INT  = 5'd7;
    localparam logic [4:0] EXT_INT_BASE = 5'd16;

    localparam logic [1:0] CSR_OP_WRITE = 2'b00;
    localparam logic [1:0] CSR_OP_SET   = 2'b01;
    localparam logic [1:0] CSR_OP_CLEAR = 2'b10;

    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    // Bit positions inside the one-hot csr_sel bus.
    localparam int CSR_SEL_MEPC    = 0;
    localparam int CSR_SEL_MCAUSE  = 1;
    localparam int CSR_SEL_MTVAL   = 2;
    localparam int CSR_SEL_MIP_EXT = 3;

    typedef logic [0:0] trap_state_t;
    localparam trap_state_t ST_IDLE = 1'b0;
    localparam trap_state_t ST_REQ  = 1'b1;

endpackage

// File: rtl/trap_ctrl_mc_int_sync_edge.sv
// Synchroniser chain for one asynchronous interrupt line plus a rising-edge
// detector on the synchronised value.
module int_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/trap_ctrl_mc.sv
// Machine-mode trap controller: synchronised level/edge external lines, sw and
// timer interrupts, fixed-priority selection, vectored dispatch, mepc/mcause/mtval.
module trap_ctrl_mc
    import trap_ctrl_mc_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_EXT_INT = 8,
    parameter int SYNC_STAGES = 2,
    parameter logic [NUM_EXT_INT-1:0] EDGE_MASK = '0
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rst,
    input  logic [NUM_EXT_INT-1:0] ext_int,
    input  logic                   timer_int,
    input  logic                   sw_int,
    input  logic [NUM_EXT_INT-1:0] mie_ext,
    input  logic                   mtie,
    input  logic                   msie,
    input  logic                   exc_valid,
    input  logic [4:0]             exc_code,
    input  logic [ADDR_WIDTH-1:0]  exc_pc,
    input  logic [DATA_WIDTH-1:0]  exc_tval,
    input  logic [ADDR_WIDTH-1:0]  pc,
    input  logic                   mret,
    output logic                   trap_req,
    input  logic                   trap_ack,
    output logic [ADDR_WIDTH-1:0]  vector_addr,
    output logic [ADDR_WIDTH-1:0]  ret_addr,
    input  logic [1:0]             mtvec_mode,
    input  logic [ADDR_WIDTH-1:0]  mtvec_base,
    input  logic                   csr_wr,
    input  logic [1:0]             csr_op,
    input  logic [3:0]             csr_sel,
    input  logic [DATA_WIDTH-1:0]  csr_wdata,
    input  logic                   csr_mie_wr,
    input  logic                   csr_mie_val,
    output logic [ADDR_WIDTH-1:0]  mepc,
    output logic [DATA_WIDTH-1:0]  mcause,
    output logic [DATA_WIDTH-1:0]  mtval,
    output logic                   mstatus_mie,
    output logic                   mstatus_mpie,
    output logic [NUM_EXT_INT+1:0] int_pending,
    output trap_state_t            dbg_state
);

    function automatic logic [DATA_WIDTH-1:0] csr_apply(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [1:0]            op,
        input logic [DATA_WIDTH-1:0] wv
    );
        case (op)
            CSR_OP_WRITE: return wv;
            CSR_OP_SET:   return old_v | wv;
            CSR_OP_CLEAR: return old_v & ~wv;
            default:      return old_v;
        endcase
    endfunction

    logic [NUM_EXT_INT-1:0] ext_sync;
    logic [NUM_EXT_INT-1:0] ext_rise;

    for (genvar i = 0; i < NUM_EXT_INT; i++) begin : g_line
        int_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk     (cpu_clk),
            .rst     (cpu_rst),
            .async_in(ext_int[i]),
            .sync_out(ext_sync[i]),
            .rise    (ext_rise[i])
        );
    end

    trap_state_t            state_q, state_d;
    logic [NUM_EXT_INT-1:0] pend_q, pend_d;
    logic                   msip_q, msip_d;
    logic                   mtip_q, mtip_d;
    logic [DATA_WIDTH-1:0]  cause_lat_q, cause_lat_d;
    logic [ADDR_WIDTH-1:0]  epc_lat_q, epc_lat_d;
    logic [DATA_WIDTH-1:0]  tval_lat_q, tval_lat_d;
    logic [ADDR_WIDTH-1:0]  vec_q, vec_d;
    logic [NUM_EXT_INT-1:0] claim_q, claim_d;
    logic [ADDR_WIDTH-1:0]  mepc_q, mepc_d;
    logic [DATA_WIDTH-1:0]  mcause_q, mcause_d;
    logic [DATA_WIDTH-1:0]  mtval_q, mtval_d;
    logic                   mie_q, mie_d;
    logic                   mpie_q, mpie_d;

    logic [NUM_EXT_INT-1:0] ext_elig;
    logic [NUM_EXT_INT-1:0] ext_onehot;
    logic [4:0]             ext_idx;
    logic                   ext_hit;
    logic                   sw_elig;
    logic                   tm_elig;
    logic [4:0]             int_code;
    logic                   trap_start;
    logic [DATA_WIDTH-1:0]  new_cause;
    logic [ADDR_WIDTH-1:0]  new_vec;
    logic                   commit;
    logic                   mip_wr;

    // Lowest-numbered eligible external line wins; exc_valid overrides all.
    always_comb begin
        ext_elig   = pend_q & mie_ext & {NUM_EXT_INT{mie_q}};
        sw_elig    = mie_q & msie & msip_q;
        tm_elig    = mie_q & mtie & mtip_q;
        ext_hit    = 1'b0;
        ext_idx    = '0;
        ext_onehot = '0;
        for (int i = NUM_EXT_INT - 1; i >= 0; i--) begin
            if (ext_elig[i]) begin
                ext_hit       = 1'b1;
                ext_idx       = 5'(i);
                ext_onehot    = '0;
                ext_onehot[i] = 1'b1;
            end
        end
        int_code   = ext_hit ? (EXT_INT_BASE + ext_idx) : (sw_elig ? M_SW_INT : M_TIMER_INT);
        trap_start = (state_q == ST_IDLE) && (exc_valid || ext_hit || sw_elig || tm_elig);

        new_cause = '0;
        if (exc_valid) begin
            new_cause[4:0] = exc_code;
        end else begin
            new_cause[DATA_WIDTH-1] = 1'b1;
            new_cause[4:0]          = int_code;
        end

        new_vec = mtvec_base;
        if (!exc_valid && mtvec_mode == MTVEC_VECTORED) begin
            new_vec = mtvec_base + ADDR_WIDTH'({int_code, 2'b00});
        end
    end

    // trap_req is high exactly in REQ; vector_addr and the latched cause stay
    // stable until trap_ack is sampled high, and trap_ack outside REQ is ignored.
    assign commit = (state_q == ST_REQ) && trap_ack;

    always_comb begin
        state_d     = state_q;
        cause_lat_d = cause_lat_q;
        epc_lat_d   = epc_lat_q;
        tval_lat_d  = tval_lat_q;
        vec_d       = vec_q;
        claim_d     = claim_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        mtval_d     = mtval_q;
        mie_d       = mie_q;
        mpie_d      = mpie_q;

        if (csr_wr && csr_sel[CSR_SEL_MEPC]) begin
            mepc_d = ADDR_WIDTH'(csr_apply(DATA_WIDTH'(mepc_q), csr_op, csr_wdata));
        end
        if (csr_wr && csr_sel[CSR_SEL_MCAUSE]) begin
            mcause_d = csr_apply(mcause_q, csr_op, csr_wdata);
        end
        if (csr_wr && csr_sel[CSR_SEL_MTVAL]) begin
            mtval_d = csr_apply(mtval_q, csr_op, csr_wdata);
        end
        if (csr_mie_wr) begin
            mie_d = csr_mie_val;
        end

        case (state_q)
            ST_IDLE: begin
                if (trap_start) begin
                    state_d     = ST_REQ;
                    cause_lat_d = new_cause;
                    epc_lat_d   = exc_valid ? exc_pc : pc;
                    tval_lat_d  = exc_valid ? exc_tval : '0;
                    vec_d       = new_vec;
                    claim_d     = exc_valid ? '0 : (ext_onehot & EDGE_MASK);
                end else if (mret) begin
                    mie_d  = mpie_q;
                    mpie_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (trap_ack) begin
                    state_d  = ST_IDLE;
                    mepc_d   = epc_lat_q;
                    mcause_d = cause_lat_q;
                    mtval_d  = tval_lat_q;
                    mpie_d   = mie_q;
                    mie_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Edge-line pending: CSR edits first, then ack-claim clear, new edge last.
    always_comb begin
        msip_d = sw_int;
        mtip_d = timer_int;
        mip_wr = csr_wr && csr_sel[CSR_SEL_MIP_EXT];
        pend_d = pend_q;
        for (int i = 0; i < NUM_EXT_INT; i++) begin
            if (!EDGE_MASK[i]) begin
                pend_d[i] = ext_sync[i];
            end else begin
                if (mip_wr) begin
                    case (csr_op)
                        CSR_OP_WRITE: pend_d[i] = csr_wdata[i];
                        CSR_OP_SET:   pend_d[i] = pend_q[i] | csr_wdata[i];
                        CSR_OP_CLEAR: pend_d[i] = pend_q[i] & ~csr_wdata[i];
                        default:      pend_d[i] = pend_q[i];
                    endcase
                end
                if (commit && claim_q[i]) begin
                    pend_d[i] = 1'b0;
                end
                if (ext_rise[i]) begin
                    pend_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            msip_q      <= 1'b0;
            mtip_q      <= 1'b0;
            cause_lat_q <= '0;
            epc_lat_q   <= '0;
            tval_lat_q  <= '0;
            vec_q       <= '0;
            claim_q     <= '0;
            mepc_q      <= '0;
            mcause_q    <= '0;
            mtval_q     <= '0;
            mie_q       <= 1'b0;
            mpie_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            msip_q      <= msip_d;
            mtip_q      <= mtip_d;
            cause_lat_q <= cause_lat_d;
            epc_lat_q   <= epc_lat_d;
            tval_lat_q  <= tval_lat_d;
            vec_q       <= vec_d;
            claim_q     <= claim_d;
            mepc_q      <= mepc_d;
            mcause_q    <= mcause_d;
            mtval_q     <= mtval_d;
            mie_q       <= mie_d;
            mpie_q      <= mpie_d;
        end
    end

    assign trap_req     = (state_q == ST_REQ);
    assign vector_addr  = vec_q;
    assign ret_addr     = mepc_q;
    assign mepc         = mepc_q;
    assign mcause       = mcause_q;
    assign mtval        = mtval_q;
    assign mstatus_mie  = mie_q;
    assign mstatus_mpie = mpie_q;
    assign int_pending  = {mtip_q, msip_q, pend_q};
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_trap_ctrl_mc.sv
// Directed bench for trap_ctrl_mc: a vector table of single-trap scenarios plus
// hand-written sequences for edge/level pending, mret, CSR races and reset in REQ.
module tb_trap_ctrl_mc;
    import trap_ctrl_mc_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = 8;
    localparam int SS = 2;
    localparam logic [N-1:0] EDGE = 8'h04;

    logic          clk = 1'b0;
    logic          cpu_rst;
    logic [N-1:0]  ext_int;
    logic          timer_int, sw_int;
    logic [N-1:0]  mie_ext;
    logic          mtie, msie;
    logic          exc_valid;
    logic [4:0]    exc_code;
    logic [AW-1:0] exc_pc;
    logic [DW-1:0] exc_tval;
    logic [AW-1:0] pc;
    logic          mret;
    logic          trap_req;
    logic          trap_ack;
    logic [AW-1:0] vector_addr, ret_addr;
    logic [1:0]    mtvec_mode;
    logic [AW-1:0] mtvec_base;
    logic          csr_wr;
    logic [1:0]    csr_op;
    logic [3:0]    csr_sel;
    logic [DW-1:0] csr_wdata;
    logic          csr_mie_wr, csr_mie_val;
    logic [AW-1:0] mepc;
    logic [DW-1:0] mcause, mtval;
    logic          mstatus_mie, mstatus_mpie;
    logic [N+1:0]  int_pending;
    trap_state_t   dbg_state;

    int checks   = 0;
    int failures = 0;

    trap_ctrl_mc #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_EXT_INT(N),
        .SYNC_STAGES(SS), .EDGE_MASK(EDGE)
    ) dut (
        .cpu_clk(clk), .cpu_rst(cpu_rst), .ext_int(ext_int),
        .timer_int(timer_int), .sw_int(sw_int), .mie_ext(mie_ext),
        .mtie(mtie), .msie(msie), .exc_valid(exc_valid), .exc_code(exc_code),
        .exc_pc(exc_pc), .exc_tval(exc_tval), .pc(pc), .mret(mret),
        .trap_req(trap_req), .trap_ack(trap_ack), .vector_addr(vector_addr),
        .ret_addr(ret_addr), .mtvec_mode(mtvec_mode), .mtvec_base(mtvec_base),
        .csr_wr(csr_wr), .csr_op(csr_op), .csr_sel(csr_sel), .csr_wdata(csr_wdata),
        .csr_mie_wr(csr_mie_wr), .csr_mie_val(csr_mie_val), .mepc(mepc),
        .mcause(mcause), .mtval(mtval), .mstatus_mie(mstatus_mie),
        .mstatus_mpie(mstatus_mpie), .int_pending(int_pending), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        exc;
        logic [4:0]  code;
        logic [31:0] epc_in;
        logic [31:0] tval_in;
        logic [7:0]  ext;
        logic        sw;
        logic        tm;
        logic [1:0]  mode;
        logic [31:0] base;
        logic [31:0] pc_in;
        int          lat;
        logic [31:0] exp_vec;
        logic [31:0] exp_cause;
        logic [31:0] exp_epc;
        logic [31:0] exp_tval;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!trap_req && n < 20) begin
            tick();
            n++;
        end
        check(nm, 32'(trap_req), 32'h1);
    endtask

    task automatic pulse_ack();
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
    endtask

    task automatic pulse_mret();
        mret = 1'b1;
        tick();
        mret = 1'b0;
    endtask

    task automatic set_mie(input logic v);
        csr_mie_wr  = 1'b1;
        csr_mie_val = v;
        tick();
        csr_mie_wr  = 1'b0;
    endtask

    task automatic csr_do(input logic [1:0] op, input logic [3:0] sel, input logic [31:0] wd);
        csr_wr    = 1'b1;
        csr_op    = op;
        csr_sel   = sel;
        csr_wdata = wd;
        tick();
        csr_wr    = 1'b0;
    endtask

    initial begin
        //          exc   code  epc_in  tval_in ext    sw    tm    mode   base          pc_in   lat vec          cause         epc     tval
        vecs[0]  = '{1'b1, 5'd2, 32'h100, 32'hDEAD, 8'h00, 1'b0, 1'b0, 2'd0, 32'h1000,     32'h999, 1, 32'h1000,     32'h2,        32'h100, 32'hDEAD};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,   32'h0,    8'h28, 1'b0, 1'b0, 2'd1, 32'h8000,     32'h200, 4, 32'h804C,     32'h80000013, 32'h200, 32'h0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,   32'h0,    8'h00, 1'b1, 1'b0, 2'd1, 32'h8000,     32'h300, 2, 32'h800C,     32'h80000003, 32'h300, 32'h0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,   32'h0,    8'h00, 1'b0, 1'b1, 2'd1, 32'h4000,     32'h304, 2, 32'h401C,     32'h80000007, 32'h304, 32'h0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,   32'h0,    8'h00, 1'b1, 1'b1, 2'd0, 32'h2000,     32'h308, 2, 32'h2000,     32'h80000003, 32'h308, 32'h0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,   32'h0,    8'hC0, 1'b0, 1'b0, 2'd1, 32'h0,        32'h30C, 4, 32'h58,       32'h80000016, 32'h30C, 32'h0};
        vecs[6]  = '{1'b1, 5'd5, 32'h404, 32'h1234, 8'h01, 1'b0, 1'b1, 2'd1, 32'h8000,     32'h500, 1, 32'h8000,     32'h5,        32'h404, 32'h1234};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,   32'h0,    8'h04, 1'b0, 1'b0, 2'd1, 32'h100,      32'h600, 4, 32'h148,      32'h80000012, 32'h600, 32'h0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,   32'h0,    8'h02, 1'b0, 1'b0, 2'd2, 32'h8000,     32'h604, 4, 32'h8000,     32'h80000011, 32'h604, 32'h0};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,   32'h0,    8'h80, 1'b0, 1'b0, 2'd1, 32'hFFFFFFF0, 32'h608, 4, 32'h4C,       32'h80000017, 32'h608, 32'h0};
        vecs[10] = '{1'b1, 5'd11, 32'h700, 32'h0,   8'h00, 1'b0, 1'b0, 2'd3, 32'h3000,     32'h998, 1, 32'h3000,     32'hB,        32'h700, 32'h0};

        cpu_rst = 1'b1;
        ext_int = '0; timer_int = 0; sw_int = 0; mie_ext = '0; mtie = 0; msie = 0;
        exc_valid = 0; exc_code = '0; exc_pc = '0; exc_tval = '0; pc = '0; mret = 0;
        trap_ack = 0; mtvec_mode = '0; mtvec_base = '0; csr_wr = 0; csr_op = '0;
        csr_sel = '0; csr_wdata = '0; csr_mie_wr = 0; csr_mie_val = 0;
        repeat (3) tick();
        check("rst_trap_req", 32'(trap_req), 32'h0);
        check("rst_vector", vector_addr, 32'h0);
        check("rst_mepc", mepc, 32'h0);
        check("rst_mcause", mcause, 32'h0);
        check("rst_mtval", mtval, 32'h0);
        check("rst_mie", 32'(mstatus_mie), 32'h0);
        check("rst_mpie", 32'(mstatus_mpie), 32'h0);
        check("rst_pending", 32'(int_pending), 32'h0);
        check("rst_ret_addr", ret_addr, 32'h0);
        cpu_rst = 1'b0;
        mie_ext = 8'hFF; mtie = 1'b1; msie = 1'b1;
        tick();

        for (int k = 0; k < NV; k++) begin
            int lat;
            mtvec_mode = vecs[k].mode;
            mtvec_base = vecs[k].base;
            pc         = vecs[k].pc_in;
            set_mie(1'b1);
            exc_valid = vecs[k].exc;
            exc_code  = vecs[k].code;
            exc_pc    = vecs[k].epc_in;
            exc_tval  = vecs[k].tval_in;
            ext_int   = vecs[k].ext;
            sw_int    = vecs[k].sw;
            timer_int = vecs[k].tm;
            lat = 0;
            while (lat < 20) begin
                tick();
                lat++;
                exc_valid = 1'b0;
                if (trap_req) break;
            end
            check($sformatf("v%0d_latency", k), 32'(lat), 32'(vecs[k].lat));
            check($sformatf("v%0d_vector", k), vector_addr, vecs[k].exp_vec);
            pulse_ack();
            check($sformatf("v%0d_req_drop", k), 32'(trap_req), 32'h0);
            check($sformatf("v%0d_mcause", k), mcause, vecs[k].exp_cause);
            check($sformatf("v%0d_mepc", k), mepc, vecs[k].exp_epc);
            check($sformatf("v%0d_ret_addr", k), ret_addr, vecs[k].exp_epc);
            check($sformatf("v%0d_mtval", k), mtval, vecs[k].exp_tval);
            check($sformatf("v%0d_mie", k), 32'(mstatus_mie), 32'h0);
            check($sformatf("v%0d_mpie", k), 32'(mstatus_mpie), 32'h1);
            ext_int = '0; sw_int = 0; timer_int = 0;
            repeat (SS + 3) tick();
            check($sformatf("v%0d_pending_clear", k), 32'(int_pending), 32'h0);
        end

        // Edge line 2 pulse while MIE=0 stays pending, traps once enabled.
        mtvec_mode = 2'd0; mtvec_base = 32'h9000; pc = 32'h610;
        ext_int = 8'h04;
        tick();
        ext_int = 8'h00;
        repeat (4) tick();
        check("edge_pending_held", 32'(int_pending), 32'h004);
        check("edge_no_trap_mie0", 32'(trap_req), 32'h0);
        set_mie(1'b1);
        wait_req("edge_trap_req");
        check("edge_vector", vector_addr, 32'h9000);
        pulse_ack();
        check("edge_mcause", mcause, 32'h80000012);
        check("edge_ack_clears", 32'(int_pending), 32'h0);

        // Level line 4 held high re-traps after each mret.
        ext_int = 8'h10;
        repeat (4) tick();
        check("level_pending", 32'(int_pending), 32'h010);
        check("level_no_trap_mie0", 32'(trap_req), 32'h0);
        pulse_mret();
        check("mret_mie", 32'(mstatus_mie), 32'h1);
        check("mret_mpie", 32'(mstatus_mpie), 32'h1);
        wait_req("level_trap_req");
        pulse_ack();
        check("level_mcause", mcause, 32'h80000014);
        pulse_mret();
        wait_req("level_retrap_req");
        pulse_ack();
        check("level_retrap_mcause", mcause, 32'h80000014);
        ext_int = 8'h00;
        repeat (SS + 3) tick();

        // Exception and eligible timer in the same cycle; timer follows mret.
        mtie = 1'b0; timer_int = 1'b1; pc = 32'h700;
        set_mie(1'b1);
        repeat (2) tick();
        check("timer_masked_no_trap", 32'(trap_req), 32'h0);
        exc_valid = 1'b1; exc_code = 5'd6; exc_pc = 32'h640; exc_tval = 32'h77; mtie = 1'b1;
        tick();
        exc_valid = 1'b0;
        check("race_trap_req", 32'(trap_req), 32'h1);
        pulse_ack();
        check("race_exc_wins", mcause, 32'h6);
        check("race_mepc", mepc, 32'h640);
        check("race_timer_pending", 32'(int_pending), 32'h200);
        pulse_mret();
        wait_req("timer_after_mret");
        // CSR write of mepc on the ack cycle loses to the trap commit.
        csr_wr = 1'b1; csr_op = CSR_OP_WRITE; csr_sel = 4'b0001; csr_wdata = 32'h40;
        pulse_ack();
        csr_wr = 1'b0;
        check("timer_mcause", mcause, 32'h80000007);
        check("commit_beats_csr", mepc, 32'h700);
        timer_int = 1'b0; mtie = 1'b0;
        pulse_mret();
        check("mret2_mie", 32'(mstatus_mie), 32'h1);
        check("mret2_mpie", 32'(mstatus_mpie), 32'h1);
        check("mret2_ret_addr", ret_addr, 32'h700);

        // Trap taken with MIE=0 records MPIE=0; mret restores MIE=0, MPIE=1.
        set_mie(1'b0);
        exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h880; exc_tval = 32'h44;
        tick();
        exc_valid = 1'b0;
        check("mie0_exc_req", 32'(trap_req), 32'h1);
        pulse_ack();
        check("mie0_exc_mcause", mcause, 32'h4);
        check("mie0_exc_mpie", 32'(mstatus_mpie), 32'h0);
        pulse_mret();
        check("mret3_mie", 32'(mstatus_mie), 32'h0);
        check("mret3_mpie", 32'(mstatus_mpie), 32'h1);

        // CSR write/set/clear in IDLE.
        csr_do(CSR_OP_WRITE, 4'b0100, 32'hF0F0);
        check("csr_mtval_write", mtval, 32'hF0F0);
        csr_do(CSR_OP_SET, 4'b0100, 32'h000F);
        check("csr_mtval_set", mtval, 32'hF0FF);
        csr_do(CSR_OP_CLEAR, 4'b0100, 32'h00F0);
        check("csr_mtval_clear", mtval, 32'hF00F);
        csr_do(CSR_OP_WRITE, 4'b0010, 32'h80000003);
        check("csr_mcause_write", mcause, 32'h80000003);
        ext_int = 8'h04;
        tick();
        ext_int = 8'h00;
        repeat (4) tick();
        check("mip_edge_set_by_line", 32'(int_pending), 32'h004);
        csr_do(CSR_OP_CLEAR, 4'b1000, 32'h04);
        check("mip_edge_csr_clear", 32'(int_pending), 32'h0);
        csr_do(CSR_OP_SET, 4'b1000, 32'h10);
        check("mip_level_set_ignored", 32'(int_pending), 32'h0);
        csr_do(CSR_OP_SET, 4'b1000, 32'h04);
        check("mip_edge_csr_set", 32'(int_pending), 32'h004);
        csr_do(CSR_OP_WRITE, 4'b1000, 32'h00);
        check("mip_edge_csr_write0", 32'(int_pending), 32'h0);

        // Reset asserted in REQ: request drops, no commit.
        exc_valid = 1'b1; exc_code = 5'd1; exc_pc = 32'h111; exc_tval = 32'h22;
        tick();
        exc_valid = 1'b0;
        check("rstreq_trap_req", 32'(trap_req), 32'h1);
        cpu_rst = 1'b1; trap_ack = 1'b1;
        tick();
        check("rstreq_req_drop", 32'(trap_req), 32'h0);
        check("rstreq_mepc", mepc, 32'h0);
        check("rstreq_mcause", mcause, 32'h0);
        check("rstreq_mtval", mtval, 32'h0);
        check("rstreq_mpie", 32'(mstatus_mpie), 32'h0);
        check("rstreq_vector", vector_addr, 32'h0);
        check("rstreq_state", 32'(dbg_state), 32'(ST_IDLE));
        cpu_rst = 1'b0; trap_ack = 1'b0;
        tick();
        check("rstreq_stays_idle", 32'(trap_req), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trap_ctrl_mc.md
# trap_ctrl_mc

Multi-channel machine-mode trap controller that sits between the core pipeline (fetch/dec/alu), the CSR file and the platform interrupt sources. It replaces the single-external-line trap logic with NUM_EXT_INT synchronised external lines, each either level- or edge-triggered, plus software and timer interrupts, fixed-priority selection and vectored dispatch. Trap entry is a registered request/acknowledge handshake with fetch. The block owns mepc/mcause/mtval and mstatus.MIE/MPIE, and handles mret.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, CSR data width
- NUM_EXT_INT, 8, external interrupt lines (1..16)
- SYNC_STAGES, 2, synchroniser flops per external line (>=2)
- EDGE_MASK, 0, NUM_EXT_INT-bit mask; bit i=1 makes line i edge-triggered
- Clock/reset (already decided): one clock; reset is synchronous and active-high.
- cpu_clk in 1 cpu clock
- cpu_rst in 1 synchronous active-high reset
- ext_int in NUM_EXT_INT async external requests
- timer_int, sw_int in 1 each, timer/software interrupt (cpu_clk domain)
- mie_ext in NUM_EXT_INT per-line enable; mtie, msie in 1 each
- exc_valid in 1 synchronous exception from pipeline; exc_code in 5; exc_pc in ADDR_WIDTH; exc_tval in DATA_WIDTH
- pc in ADDR_WIDTH address of first not-executed instruction
- mret in 1 mret retiring
- trap_req out 1; trap_ack in 1 (fetch flushed, redirecting)
- vector_addr out ADDR_WIDTH trap target, valid while trap_req
- ret_addr out ADDR_WIDTH = mepc
- mtvec_mode in 2; mtvec_base in ADDR_WIDTH
- csr_wr in 1; csr_op in 2 (00 write, 01 set, 10 clear); csr_sel in 4 one-hot {mip_ext, mtval, mcause, mepc}; csr_wdata in DATA_WIDTH
- csr_mie_wr in 1, csr_mie_val in 1 direct MIE write (mstatus path)
- mepc, mcause, mtval out ADDR/DATA/DATA widths
- mstatus_mie, mstatus_mpie out 1 each
- int_pending out NUM_EXT_INT+2 {mtip, msip, ext pending}

## Operation
- Reset: all sync flops, pending bits, mepc, mcause, mtval, MIE, MPIE, trap_req, vector_addr = 0; state IDLE.
- Level line: pending[i] = synced level, registered. Edge line: set on synced 0->1; cleared by trap_ack when line i is the taken cause, or by a csr clear/write of mip_ext bit i. Set and clear in the same cycle: set wins. csr write/set on level lines is ignored.
- msip/mtip: sw_int/timer_int registered once.
- Eligible interrupt: MIE & enable & pending. Priority: exc_valid > ext line 0 … ext line N-1 > software > timer.
- Cause codes: exception = {0, exc_code}; ext line i = {1, 16+i}; software = {1, 3}; timer = {1, 7}; MSB = DATA_WIDTH-1.
- FSM IDLE: if exc_valid or any eligible interrupt, latch cause, epc (exc_pc for exception, pc for interrupt), tval (exc_tval or 0) and vector, and go to REQ.
- FSM REQ: trap_req=1, latched values held stable. exc_valid and new interrupts are ignored. On trap_ack, commit mepc/mcause/mtval, set MPIE<=MIE and MIE<=0, clear the claimed edge pending bit, and return to IDLE.
- Vector: mode 00 = base. Mode 01: exception = base; interrupt = base + (cause[4:0]<<2), truncated to ADDR_WIDTH. Other modes behave as 00.
- mret in IDLE with no trap starting: MIE<=MPIE, MPIE<=1. If a trap starts the same cycle, the trap wins and mret is dropped (the pipeline flushes it). mret in REQ is ignored.
- CSR write/set/clear applies to the selected register. A trap commit in the same cycle wins over a CSR write to mepc/mcause/mtval/MIE.

## Timing
- exc_valid at cycle t -> trap_req at t+1.
- sw/timer input at t -> pending at t+1 -> trap_req at t+2.
- ext_int at t -> synced at t+SYNC_STAGES -> pending at t+SYNC_STAGES+1 -> trap_req at t+SYNC_STAGES+2.
- trap_ack sampled only while trap_req=1. CSR outputs update on the edge after ack. Earliest next trap_req is 2 cycles after ack.
- ret_addr is combinational from the mepc register.
- Reset asserted in REQ: trap_req drops on the next edge with no commit.

## Structure
- Shared package: cause constants (M_SW_INT 3, M_TIMER_INT 7, EXT_INT_BASE 16), csr_op encodings, FSM state typedef.
- Sub-module int_sync_edge (SYNC_STAGES flops + edge detect), instantiated per line.

## Test plan
- exc_valid=1, exc_code=2, exc_pc=0x100, exc_tval=0xDEAD at t -> trap_req at t+1; after ack, mepc=0x100, mcause=2, mtval=0xDEAD, MIE=0, MPIE=old MIE.
- MIE=1, ext lines 3 and 5 enabled and asserted together, mtvec_mode=01, base=0x8000 -> mcause=0x80000013, vector_addr=0x804C.
- Edge line 2: one-cycle pulse while MIE=0 -> pending stays set. Set MIE -> trap; ack clears pending[2]. A level line held high re-traps after mret.
- exc_valid and eligible timer interrupt in the same cycle -> exception taken, timer trap follows after the next mret.
- CSR write of mepc=0x40 on the ack cycle -> trap epc wins. Then mret in IDLE -> MIE=MPIE, MPIE=1, ret_addr=epc.
- cpu_rst asserted during REQ -> all outputs return to 0 and no commit occurs.
